ring_osc_meas_ctrl: RTL and testbench
=====================================

// Module: ring_osc_meas_ctrl
// PURPOSE
//  Sequences one ring-oscillator frequency measurement. Runs in the clk domain.
//  - Enables the ring through its nrst input.
//  - Opens a counting window of a programmed number of clk cycles.
//  - Stops the ring and returns the frozen edge count with a done/ack handshake.
//  Sits between the chip I/O (clk = scan clock) and the ring_osc instance; owns the osc-domain counter.
// PARAMETERS
//  CNT_W         16  width of osc edge counter and of count_out
//  GATE_BASE     1   gate length unit in clk cycles; window = GATE_BASE << gate_sel
//  WARM_CYCLES   2   clk cycles ring runs, counter disabled, before window opens
//  SETTLE_CYCLES 3   clk cycles after ring stop before count is captured (>=2)
// PORTS
//  clk        in   1      measurement/scan clock; all FSM state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      pulse/level; begins a measurement when sampled in IDLE or DONE
//  gate_sel   in   2      window = GATE_BASE<<gate_sel clk cycles (1,2,4,8 at defaults); sampled at start
//  ack        in   1      clears done/result-valid in DONE
//  osc        in   1      ring_osc output (async to clk)
//  ring_nrst  out  1      to ring_osc nrst; 1 = ring runs, 0 = ring held stopped (osc high)
//  busy       out  1      1 in WARMUP/GATE/SETTLE
//  done       out  1      1 in DONE; count_out/ovf valid
//  count_out  out  CNT_W  captured edge count, held until next capture or reset
//  ovf        out  1      osc counter saturated during this measurement
// BEHAVIOUR
//  - Reset (async): state IDLE, ring_nrst=0, cnt_clr=1, busy=0, done=0, count_out=0, ovf=0.
//    Reset mid-measurement stops the ring immediately; no partial result is reported.
//  - FSM states: IDLE, WARMUP, GATE, SETTLE, DONE. Single down-counter tmr sized for max(window, WARM, SETTLE).
//  - IDLE:
//      ring_nrst=0, cnt_clr=1, cnt_en=0.
//      start=1 -> latch gate_sel, tmr=WARM_CYCLES-1, go WARMUP.
//  - WARMUP:
//      ring_nrst=1, cnt_clr=0, cnt_en=0.
//      tmr==0 -> tmr=window-1, go GATE.
//  - GATE:
//      ring_nrst=1, cnt_en=1.
//      tmr==0 -> tmr=SETTLE_CYCLES-1, go SETTLE.
//      Window is exactly `window` clk cycles of cnt_en high.
//  - SETTLE:
//      ring_nrst=0, cnt_en=0; ring stops, counter frozen.
//      tmr==0 -> count_out<=osc_cnt, ovf<=osc_sat, go DONE.
//  - DONE:
//      done=1; ring stays stopped.
//      ack=1 -> IDLE.
//      start=1 (with or without ack) -> implicit ack, restart directly into WARMUP with new gate_sel.
//      start wins over ack.
//  - start in WARMUP/GATE/SETTLE is ignored (no queuing).
//  - Counter (osc domain):
//      cnt_en passes through a 2-flop synchroniser clocked by osc.
//      Counts osc rising edges while the synced enable is 1.
//      Saturates at 2^CNT_W-1 and sets sticky osc_sat; no wrap.
//      cnt_clr is an async clear of counter and osc_sat.
//  - Accuracy: result = edges in window +/-2 from synchroniser latency on open and close. Documented, not corrected.
//  - CDC: osc_cnt is read only in SETTLE end, after ring stopped >= SETTLE_CYCLES clk (quiescent bus).
//    No Gray coding needed; SETTLE_CYCLES < 2 is illegal (assertion).
// STRUCTURE
//  - Shared package ring_meas_pkg:
//      state enum {IDLE,WARMUP,GATE,SETTLE,DONE}, 3-bit encoding;
//      GATE_SEL_W=2;
//      function window_len(gate_sel).
//  - Sub-module ring_edge_counter (osc-domain):
//      ports osc, cnt_clr, cnt_en, count[CNT_W], sat;
//      contains the 2-flop enable synchroniser.
//  - Top holds FSM, timer, capture regs; instantiates ring_osc (nrst<=ring_nrst) and ring_edge_counter.
//    In the bench, ring_osc is replaced by a behavioural oscillator model.
// TESTING
//  - clk 1000ns; osc model 6ns period gated by ring_nrst; gate_sel=0, start pulse
//    -> busy 1 cycle after start; done after 1+2+1+3 cycles; count_out in 165..169; ovf=0.
//  - Same osc; gate_sel=3 -> count_out in 1331..1335; gate length checked by counting cnt_en-high clk cycles = 8.
//  - CNT_W=8, gate_sel=1, osc 6ns -> count_out=255, ovf=1; next measurement with gate_sel=0, CNT_W=8,
//    osc 10ns -> ovf=0, count_out ~100.
//  - start held high continuously
//    -> back-to-back measurements, done high exactly 1 cycle each; start during GATE ignored (window unchanged).
//  - rst asserted mid-GATE -> ring_nrst=0 same time step, done=0, count_out=0; after release, fresh measurement correct.
//  - In DONE, ack=1 -> IDLE next cycle; count_out held; ring_nrst stays 0 through IDLE and DONE (osc stable high).

Source files
------------

// File: rtl/ring_osc_meas_ctrl_pkg.sv
`timescale 1ns/1ps
// Shared state encoding and helpers for the ring-oscillator measurement controller.
package ring_meas_pkg;

    localparam int GATE_SEL_W = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WARMUP = 3'd1,
        S_GATE   = 3'd2,
        S_SETTLE = 3'd3,
        S_DONE   = 3'd4
    } meas_state_t;

    // Counting window length in clk cycles for a given gate selection.
    function automatic int unsigned window_len(input int unsigned base,
                                               input logic [GATE_SEL_W-1:0] sel);
        return base << sel;
    endfunction

    // Largest of three values; used to size the shared down-timer.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/ring_osc_meas_ctrl_edge_counter.sv
`timescale 1ns/1ps
// Osc-domain edge counter: synchronises the clk-domain enable into the osc
// domain and counts rising osc edges, saturating instead of wrapping.
module ring_edge_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_osc,
    input  logic             i_cnt_clr,
    input  logic             i_cnt_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_sat
);

    logic [1:0]       r_en_sync;
    logic [CNT_W-1:0] r_count;
    logic             r_sat;

    // Two-flop synchroniser for the enable, cleared together with the count.
    always_ff @(posedge i_osc or posedge i_cnt_clr) begin
        if (i_cnt_clr) begin
            r_en_sync <= 2'b00;
        end else begin
            r_en_sync <= {r_en_sync[0], i_cnt_en};
        end
    end

    // Count edges while enabled; an edge arriving at full scale sets the sticky flag.
    always_ff @(posedge i_osc or posedge i_cnt_clr) begin
        if (i_cnt_clr) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (r_en_sync[1]) begin
            if (r_count == {CNT_W{1'b1}}) begin
                r_sat <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_count = r_count;
    assign o_sat   = r_sat;

endmodule

// File: rtl/ring_osc_meas_ctrl.sv
`timescale 1ns/1ps
// Ring-oscillator measurement sequencer: warms the ring up, opens a counting
// window of a programmed number of clk cycles, stops the ring, waits for the
// osc-domain counter to go quiet and captures the result. The ring_osc macro
// itself is wired at chip level: its nrst comes from o_ring_nrst and its
// output returns on i_osc.
module ring_osc_meas_ctrl
    import ring_meas_pkg::*;
#(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned GATE_BASE     = 1,
    parameter int unsigned WARM_CYCLES   = 2,
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [GATE_SEL_W-1:0] i_gate_sel,
    input  logic                  i_ack,
    input  logic                  i_osc,
    output logic                  o_ring_nrst,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [CNT_W-1:0]      o_count_out,
    output logic                  o_ovf
);

    localparam int unsigned MAX_T = max3(window_len(GATE_BASE, {GATE_SEL_W{1'b1}}),
                                         WARM_CYCLES, SETTLE_CYCLES);
    localparam int unsigned TMR_W = $clog2(MAX_T);

    // The counter bus is read without synchronisation, so it must be quiet
    // for at least two clk cycles after the ring stops.
    if (SETTLE_CYCLES < 2) begin : g_settle_check
        $error("SETTLE_CYCLES must be at least 2");
    end
    if (WARM_CYCLES < 1) begin : g_warm_check
        $error("WARM_CYCLES must be at least 1");
    end

    meas_state_t           r_state, w_state_next;
    logic [TMR_W-1:0]      r_tmr, w_tmr_next;
    logic [GATE_SEL_W-1:0] r_gate_sel, w_gate_sel_next;
    logic                  r_ring_nrst, r_cnt_en, r_cnt_clr, r_busy, r_done;
    logic                  w_ring_nrst_next, w_cnt_en_next, w_cnt_clr_next;
    logic                  w_busy_next, w_done_next, w_capture, w_tmr_zero;
    logic [CNT_W-1:0]      r_count_out, w_osc_cnt;
    logic                  r_ovf, w_osc_sat;

    assign w_tmr_zero = (r_tmr == '0);

    // Next-state, timer reload and the per-state control levels.
    always_comb begin
        w_state_next    = r_state;
        w_tmr_next      = r_tmr;
        w_gate_sel_next = r_gate_sel;
        w_capture       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_gate_sel_next = i_gate_sel;
                    w_tmr_next      = TMR_W'(WARM_CYCLES - 1);
                    w_state_next    = S_WARMUP;
                end
            end
            S_WARMUP: begin
                if (w_tmr_zero) begin
                    w_tmr_next   = TMR_W'(window_len(GATE_BASE, r_gate_sel) - 1);
                    w_state_next = S_GATE;
                end else begin
                    w_tmr_next = r_tmr - 1'b1;
                end
            end
            S_GATE: begin
                if (w_tmr_zero) begin
                    w_tmr_next   = TMR_W'(SETTLE_CYCLES - 1);
                    w_state_next = S_SETTLE;
                end else begin
                    w_tmr_next = r_tmr - 1'b1;
                end
            end
            S_SETTLE: begin
                if (w_tmr_zero) begin
                    w_capture    = 1'b1;
                    w_state_next = S_DONE;
                end else begin
                    w_tmr_next = r_tmr - 1'b1;
                end
            end
            S_DONE: begin
                // A new start doubles as the acknowledge and wins over ack.
                if (i_start) begin
                    w_gate_sel_next = i_gate_sel;
                    w_tmr_next      = TMR_W'(WARM_CYCLES - 1);
                    w_state_next    = S_WARMUP;
                end else if (i_ack) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // Controls are registered from the next state so the async counter
        // clear and the ring enable never see decode glitches. The counter is
        // also cleared in DONE so a direct restart begins from zero.
        w_ring_nrst_next = (w_state_next == S_WARMUP) || (w_state_next == S_GATE);
        w_cnt_en_next    = (w_state_next == S_GATE);
        w_cnt_clr_next   = (w_state_next == S_IDLE) || (w_state_next == S_DONE);
        w_busy_next      = (w_state_next == S_WARMUP) || (w_state_next == S_GATE) ||
                           (w_state_next == S_SETTLE);
        w_done_next      = (w_state_next == S_DONE);
    end

    // State, timer and control registers; reset stops the ring at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tmr       <= '0;
            r_gate_sel  <= '0;
            r_ring_nrst <= 1'b0;
            r_cnt_en    <= 1'b0;
            r_cnt_clr   <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_tmr       <= w_tmr_next;
            r_gate_sel  <= w_gate_sel_next;
            r_ring_nrst <= w_ring_nrst_next;
            r_cnt_en    <= w_cnt_en_next;
            r_cnt_clr   <= w_cnt_clr_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
        end
    end

    // Result capture at the end of SETTLE; held until the next capture or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count_out <= '0;
            r_ovf       <= 1'b0;
        end else if (w_capture) begin
            r_count_out <= w_osc_cnt;
            r_ovf       <= w_osc_sat;
        end
    end

    ring_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .i_osc     (i_osc),
        .i_cnt_clr (r_cnt_clr),
        .i_cnt_en  (r_cnt_en),
        .o_count   (w_osc_cnt),
        .o_sat     (w_osc_sat)
    );

    assign o_ring_nrst = r_ring_nrst;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_count_out = r_count_out;
    assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_ring_osc_meas_ctrl.sv
`timescale 1ns/1ps
// Bench for ring_osc_meas_ctrl: two instances (16-bit and 8-bit counters)
// share the stimulus; a timeline model predicts every output each cycle.
module tb_ring_osc_meas_ctrl;

    localparam int WARM = 2;
    localparam int SETT = 3;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic       ack   = 1'b0;
    logic [1:0] gsel  = 2'd0;
    logic       osc_raw;
    int         half_ns = 3;

    logic        nrst16, busy16, done16, ovf16, osc16;
    logic [15:0] cnt16;
    logic        nrst8, busy8, done8, ovf8, osc8;
    logic [7:0]  cnt8;

    int total = 0;
    int bad   = 0;

    // Behavioural ring: free-running raw wave, forced high while held stopped.
    assign osc16 = osc_raw | ~nrst16;
    assign osc8  = osc_raw | ~nrst8;

    always #500 clk = ~clk;

    initial begin
        osc_raw = 1'b1;
        #0.5;
        forever begin
            osc_raw = ~osc_raw;
            #(half_ns);
        end
    end

    ring_osc_meas_ctrl #(.CNT_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .i_start(start), .i_gate_sel(gsel), .i_ack(ack),
        .i_osc(osc16), .o_ring_nrst(nrst16), .o_busy(busy16), .o_done(done16),
        .o_count_out(cnt16), .o_ovf(ovf16)
    );

    ring_osc_meas_ctrl #(.CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .i_start(start), .i_gate_sel(gsel), .i_ack(ack),
        .i_osc(osc8), .o_ring_nrst(nrst8), .o_busy(busy8), .o_done(done8),
        .o_count_out(cnt8), .o_ovf(ovf8)
    );

    // ---------------- reference model (timeline arithmetic) ----------------
    int     m_e = 0, m_e0 = 0, m_w = 1, m_len = 0;
    bit     m_active = 1'b0, m_gate = 1'b0;
    int     n_edges = 0, n_base = 0, meas_no = 0;
    longint lo16 = 0, hi16 = 0, lo8 = 0, hi8 = 0;
    bit     e_ovf8 = 1'b0, ovf8_dc = 1'b0;

    // Osc rising edges that fall inside the model's counting window.
    always @(posedge osc16) if (m_gate) n_edges++;

    always @(posedge clk or posedge rst) begin
        bit busy_prev;
        int n;
        if (rst) begin
            m_active = 1'b0;
            m_gate   = 1'b0;
            lo16 = 0; hi16 = 0; lo8 = 0; hi8 = 0;
            e_ovf8 = 1'b0; ovf8_dc = 1'b0;
        end else begin
            m_e++;
            busy_prev = m_active && (m_e - 1 < m_e0 + m_len);
            if (m_active && (m_e == m_e0 + m_len)) begin
                n    = n_edges - n_base;
                lo16 = (n > 2) ? n - 2 : 0;
                hi16 = n + 2;
                lo8  = (lo16 > 255) ? 255 : lo16;
                hi8  = (hi16 > 255) ? 255 : hi16;
                e_ovf8  = (n > 255);
                ovf8_dc = (n >= 254) && (n <= 259);
                meas_no++;
                $display("meas %0d: window=%0d edges=%0d count16=%0d..%0d count8=%0d..%0d",
                         meas_no, m_w, n, lo16, hi16, lo8, hi8);
            end else if (!busy_prev) begin
                if (start) begin
                    m_active = 1'b1;
                    m_e0     = m_e;
                    m_w      = 1 << gsel;
                    m_len    = WARM + m_w + SETT;
                    n_base   = n_edges;
                end else if (ack) begin
                    m_active = 1'b0;
                end
            end
            m_gate = m_active && (m_e >= m_e0 + WARM) && (m_e < m_e0 + WARM + m_w);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input longint act, input longint lo, input longint hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: actual=%0d required=%0d..%0d t=%0t", nm, act, lo, hi, $time);
        end
    endtask

    task automatic compare_cycle();
        bit eb, ed, en;
        eb = m_active && (m_e < m_e0 + m_len);
        ed = m_active && (m_e >= m_e0 + m_len);
        en = m_active && (m_e < m_e0 + WARM + m_w);
        chk("busy16", busy16, eb, eb);
        chk("busy8", busy8, eb, eb);
        chk("done16", done16, ed, ed);
        chk("done8", done8, ed, ed);
        chk("ring_nrst16", nrst16, en, en);
        chk("ring_nrst8", nrst8, en, en);
        chk("count16", cnt16, lo16, hi16);
        chk("count8", cnt8, lo8, hi8);
        chk("ovf16", ovf16, 0, 0);
        if (!ovf8_dc) chk("ovf8", ovf8, e_ovf8, e_ovf8);
    endtask

    task automatic measure(input logic [1:0] gs, output int lat);
        @(negedge clk);
        #100 start = 1'b1; gsel = gs;
        @(negedge clk);
        lat = 1;
        chk("busy_after_start", busy16, 1, 1);
        #100 start = 1'b0;
        while (!done16 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("done_reached", done16, 1, 1);
    endtask

    task automatic do_ack();
        #100 ack = 1'b1;
        @(negedge clk);
        chk("ack_done_clr", done16, 0, 0);
        chk("ack_busy", busy16, 0, 0);
        chk("ack_cnt_held", cnt16, lo16, hi16);
        chk("ack_nrst", nrst16, 0, 0);
        #100 ack = 1'b0;
    endtask

    initial begin
        bit sim_end;
        int lat, run, ndone;
        sim_end = 1'b0;
        #1 rst = 1'b1;
        fork
            begin : cmp
                while (!sim_end) begin
                    @(negedge clk);
                    if (!sim_end) compare_cycle();
                end
            end
            begin : stim
                repeat (3) @(negedge clk);
                chk("rst_nrst", nrst16, 0, 0);
                chk("rst_busy", busy16, 0, 0);
                chk("rst_done", done16, 0, 0);
                chk("rst_count", cnt16, 0, 0);
                chk("rst_ovf", ovf16, 0, 0);
                #100 rst = 1'b0;

                measure(2'd0, lat);
                chk("lat_g0", lat, 7, 7);
                chk("cnt_g0", cnt16, 165, 169);
                chk("ovf_g0", ovf16, 0, 0);
                do_ack();

                measure(2'd3, lat);
                chk("lat_g3", lat, 14, 14);
                chk("cnt_g3", cnt16, 1331, 1335);
                do_ack();

                measure(2'd1, lat);
                chk("cnt8_sat", cnt8, 255, 255);
                chk("ovf8_sat", ovf8, 1, 1);
                do_ack();

                half_ns = 5;
                measure(2'd0, lat);
                chk("cnt8_slow", cnt8, 97, 102);
                chk("ovf8_slow", ovf8, 0, 0);
                do_ack();
                half_ns = 3;

                // start held high: back-to-back runs, done one cycle each
                @(negedge clk);
                #100 start = 1'b1;
                run = 0; ndone = 0;
                for (int i = 0; i < 60; i++) begin
                    @(negedge clk);
                    if (done16) run++;
                    else if (run > 0) begin
                        chk("done_one_cycle", run, 1, 1);
                        ndone++;
                        run = 0;
                    end
                    #100 gsel = 2'($urandom_range(3));
                end
                start = 1'b0;
                chk("held_meas_count", ndone, 3, 60);
                for (int i = 0; i < 20 && busy16; i++) @(negedge clk);

                // reset in the middle of the counting window
                @(negedge clk);
                #100 start = 1'b1; gsel = 2'd3;
                @(negedge clk);
                #100 start = 1'b0;
                repeat (3) @(negedge clk);
                chk("pre_rst_busy", busy16, 1, 1);
                #200 rst = 1'b1;
                #1;
                chk("rst_mid_nrst16", nrst16, 0, 0);
                chk("rst_mid_nrst8", nrst8, 0, 0);
                chk("rst_mid_done", done16, 0, 0);
                chk("rst_mid_busy", busy16, 0, 0);
                chk("rst_mid_count", cnt16, 0, 0);
                @(negedge clk);
                #100 rst = 1'b0;
                measure(2'd0, lat);
                chk("lat_after_rst", lat, 7, 7);
                chk("cnt_after_rst", cnt16, 165, 169);
                do_ack();

                // randomized traffic
                for (int i = 0; i < 500; i++) begin
                    @(negedge clk);
                    #100;
                    rst   = 1'b0;
                    start = ($urandom_range(3) == 0);
                    ack   = ($urandom_range(2) == 0);
                    gsel  = 2'($urandom_range(3));
                    if ($urandom_range(39) == 0) half_ns = (half_ns == 3) ? 5 : 3;
                    if ($urandom_range(149) == 0) rst = 1'b1;
                end
                @(negedge clk);
                #100 rst = 1'b0; start = 1'b0; ack = 1'b0;
                repeat (3) @(negedge clk);
                sim_end = 1'b1;
            end
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
